// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: default geometry constants,
// the fetch-address field split and the miss-handling FSM state encoding.
package cpu_types_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = 4;
    localparam int ICACHE_TAG_W = 26;

    // Fetch address split for the default 16-frame geometry.
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    // IDLE serves lookups, FETCH waits for the single-word fill.
    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One combinational read port, one synchronous write port; RST clears
// every valid bit synchronously (tag/data contents are left as they are).
module icache_frame_array #(
    parameter int SETS  = 16,
    parameter int TAG_W = 26
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [$clog2(SETS)-1:0]  rd_idx,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [31:0]              rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(SETS)-1:0]  wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [31:0]              wr_data
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];

    // Valid bits: cleared by reset, set by a fill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= {SETS{1'b0}};
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end else begin
            valid <= valid;
        end
    end

    // Tag and data storage written on fill; a reset cycle drops the write.
    always_ff @(posedge CLK) begin
        if (wr_en && !RST) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache. Hits are served in the request
// cycle; a miss latches the word address and runs one single-word fill.
// Optional hit/miss statistics counters: define ICACHE_STATS_EN.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t    state;
    icache_state_t    next_state;
    logic [29:0]      miss_word;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             lookup_hit;
    logic             fill_en;
    logic             unused_offset;

    assign req_tag       = imemaddr[31:32-TAG_W];
    assign req_idx       = imemaddr[31-TAG_W:2];
    assign unused_offset = ^imemaddr[1:0];
    assign lookup_hit    = imemREN && rd_valid && (rd_tag == req_tag);
    assign fill_en       = (state == FETCH) && !iwait;

    icache_frame_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_en),
        .wr_idx   (miss_word[IDX_W-1:0]),
        .wr_tag   (miss_word[29:IDX_W]),
        .wr_data  (iload)
    );

    // State register and miss word address captured on the IDLE->FETCH step.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            miss_word <= 30'd0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && (next_state == FETCH)) begin
                miss_word <= imemaddr[31:2];
            end
        end
    end

    // Next state: a miss starts a fill, which runs to completion regardless of fetch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (imemREN && !lookup_hit) begin
                    next_state = FETCH;
                end else begin
                    next_state = IDLE;
                end
            end
            FETCH: begin
                if (!iwait) begin
                    next_state = IDLE;
                end else begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs: hit path only in IDLE, memory request held stable through FETCH.
    always_comb begin
        ihit     = 1'b0;
        imemload = 32'd0;
        iREN     = 1'b0;
        iaddr    = 32'd0;
        case (state)
            IDLE: begin
                ihit = lookup_hit;
                if (lookup_hit) begin
                    imemload = rd_data;
                end else begin
                    imemload = 32'd0;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_word, 2'b00};
            end
            default: begin
                iREN  = 1'b0;
                iaddr = 32'd0;
            end
        endcase
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit/miss statistics.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (ihit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if ((state == IDLE) && (next_state == FETCH) && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
